// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson-code decoder: FSM encoding, error
// counter sizing and code helpers. johnson_next() is also usable as a
// reference model by verification code.
package johnson_pkg;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } dec_state_e;

  localparam int ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = 8'd255;

  // Helpers work on a fixed wide container; callers zero-extend their code
  // and pass the real width, then cast the result back down.
  localparam int CODE_MAX_W = 32;

  // Next code in counter order: {code[W-2:0], ~code[W-1]}.
  function automatic logic [CODE_MAX_W-1:0] johnson_next(
    input logic [CODE_MAX_W-1:0] code,
    input int                    width
  );
    logic [CODE_MAX_W-1:0] nxt;
    logic                  top;
    nxt = {CODE_MAX_W{1'b0}};
    top = 1'b0;
    for (int i = 0; i < CODE_MAX_W; i++) begin
      if (i == width - 1) begin
        top = code[i];
      end else begin
        top = top;
      end
    end
    for (int i = 1; i < CODE_MAX_W; i++) begin
      if (i < width) begin
        nxt[i] = code[i-1];
      end else begin
        nxt[i] = 1'b0;
      end
    end
    nxt[0] = ~top;
    return nxt;
  endfunction

  // True when the two words differ in exactly one bit position.
  function automatic logic one_bit_diff(
    input logic [CODE_MAX_W-1:0] a,
    input logic [CODE_MAX_W-1:0] b
  );
    return ($countones(a ^ b) == 32'd1);
  endfunction

endpackage

// File: rtl/johnson_classify.sv
// Combinational Johnson word classifier: decides whether a WIDTH-bit word is
// a legal Johnson code and, if so, its position in the counter sequence.
module johnson_classify
  import johnson_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int IW    = $clog2(2*WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic             legal,
  output logic [IW-1:0]    idx
);

  logic [IW:0]      pc_s;
  logic [IW:0]      neg_idx_s;
  logic [WIDTH-1:0] lsb_mask_s;
  logic [WIDTH-1:0] msb_mask_s;
  logic             lsb_run_s;
  logic             msb_run_s;

  // Popcount, then compare against the only two legal shapes of that weight.
  always_comb begin
    pc_s       = {(IW+1){1'b0}};
    lsb_mask_s = {WIDTH{1'b0}};
    msb_mask_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      pc_s = pc_s + {{IW{1'b0}}, code[i]};
    end
    for (int i = 0; i < WIDTH; i++) begin
      lsb_mask_s[i] = ((IW+1)'(i) < pc_s);
      msb_mask_s[i] = (((IW+1)'(i) + pc_s) >= (IW+1)'(WIDTH));
    end
    lsb_run_s = (code == lsb_mask_s);
    // A top-aligned run must be nonzero and leave bit 0 clear; all-ones is
    // already covered by the bottom-aligned case.
    msb_run_s = (code == msb_mask_s) && (pc_s != {(IW+1){1'b0}}) && !code[0];
    neg_idx_s = (IW+1)'(2*WIDTH) - pc_s;
    if (lsb_run_s) begin
      legal = 1'b1;
      idx   = pc_s[IW-1:0];
    end else if (msb_run_s) begin
      legal = 1'b1;
      idx   = neg_idx_s[IW-1:0];
    end else begin
      legal = 1'b0;
      idx   = {IW{1'b0}};
    end
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code receive decoder: decodes each valid sample to a state index,
// flags illegal words and out-of-sequence steps, tracks lock to the
// sequence and keeps a saturating error count. All outputs are registered.
// Optional single-bit correction while locked: define JOHNSON_DEC_CORRECT_EN.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int LOCK_CNT = 3,
  localparam int IW       = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_code,
  input  logic             err_clr,
  output logic [IW-1:0]    idx_out,
  output logic             idx_valid,
  output logic             illegal,
  output logic             seq_err,
  output logic             corrected,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam int SW = $clog2(LOCK_CNT + 1);

  dec_state_e       state_r;
  logic [SW-1:0]    step_r;
  logic             prev_valid_r;
  logic [WIDTH-1:0] prev_code_r;

  logic             cls_legal_s;
  logic [IW-1:0]    cls_idx_s;
  logic [WIDTH-1:0] exp_code_s;
  logic             is_succ_s;
  logic             lock_hit_s;
  logic             fix_s;
  logic             err_event_s;
`ifdef JOHNSON_DEC_CORRECT_EN
  localparam logic [IW-1:0] LAST_IDX = IW'(2*WIDTH - 1);
  logic [IW-1:0]    exp_idx_s;
`endif

  johnson_classify #(.WIDTH(WIDTH)) u_classify (
    .code  (in_code),
    .legal (cls_legal_s),
    .idx   (cls_idx_s)
  );

  // Successor check in the code domain, lock threshold and error event.
  always_comb begin
    exp_code_s = WIDTH'(johnson_next({{(CODE_MAX_W-WIDTH){1'b0}}, prev_code_r}, WIDTH));
    is_succ_s  = prev_valid_r && cls_legal_s && (in_code == exp_code_s);
    lock_hit_s = (step_r >= SW'(LOCK_CNT - 1));
`ifdef JOHNSON_DEC_CORRECT_EN
    // idx_out always holds the last accepted index while prev_valid_r is set.
    if (idx_out == LAST_IDX) begin
      exp_idx_s = {IW{1'b0}};
    end else begin
      exp_idx_s = idx_out + IW'(1);
    end
    fix_s = in_valid && !cls_legal_s && (state_r == ST_LOCKED) && prev_valid_r &&
            one_bit_diff({{(CODE_MAX_W-WIDTH){1'b0}}, in_code},
                         {{(CODE_MAX_W-WIDTH){1'b0}}, exp_code_s});
`else
    fix_s = 1'b0;
`endif
    err_event_s = in_valid && !fix_s &&
                  (!cls_legal_s || ((state_r == ST_LOCKED) && !is_succ_s));
  end

  // Lock FSM, sequence tracking and registered decode outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_UNLOCKED;
      step_r       <= {SW{1'b0}};
      prev_valid_r <= 1'b0;
      prev_code_r  <= {WIDTH{1'b0}};
      idx_out      <= {IW{1'b0}};
      idx_valid    <= 1'b0;
      illegal      <= 1'b0;
      seq_err      <= 1'b0;
      corrected    <= 1'b0;
      locked       <= 1'b0;
    end else begin
      idx_valid <= 1'b0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      corrected <= 1'b0;
      if (in_valid) begin
        if (fix_s) begin
`ifdef JOHNSON_DEC_CORRECT_EN
          corrected   <= 1'b1;
          idx_valid   <= 1'b1;
          idx_out     <= exp_idx_s;
          prev_code_r <= exp_code_s;
`endif
        end else if (!cls_legal_s) begin
          illegal      <= 1'b1;
          state_r      <= ST_UNLOCKED;
          locked       <= 1'b0;
          step_r       <= {SW{1'b0}};
          prev_valid_r <= 1'b0;
        end else begin
          idx_valid    <= 1'b1;
          idx_out      <= cls_idx_s;
          prev_code_r  <= in_code;
          prev_valid_r <= 1'b1;
          case (state_r)
            ST_LOCKED: begin
              if (!is_succ_s) begin
                seq_err <= 1'b1;
                state_r <= ST_UNLOCKED;
                locked  <= 1'b0;
                step_r  <= {SW{1'b0}};
              end
            end
            ST_UNLOCKED: begin
              if (is_succ_s) begin
                if (lock_hit_s) begin
                  state_r <= ST_LOCKED;
                  locked  <= 1'b1;
                  step_r  <= SW'(LOCK_CNT);
                end else begin
                  step_r <= step_r + SW'(1);
                end
              end else begin
                step_r <= {SW{1'b0}};
              end
            end
            default: begin
              state_r <= ST_UNLOCKED;
              locked  <= 1'b0;
              step_r  <= {SW{1'b0}};
            end
          endcase
        end
      end
    end
  end

  // Saturating error counter; a clear coinciding with an error leaves 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count <= {ERR_W{1'b0}};
    end else if (err_clr) begin
      err_count <= err_event_s ? 8'd1 : 8'd0;
    end else if (err_event_s && (err_count != ERR_MAX)) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench for johnson_decoder (WIDTH=4, LOCK_CNT=3): directed
// scenarios plus random traffic, compared every cycle against a table-based
// behavioural model.
module tb_johnson_decoder;

  localparam int W  = 4;
  localparam int LK = 3;
  localparam int N  = 2 * W;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_code = '0;
  logic         err_clr = 1'b0;
  logic [2:0]   idx_out;
  logic         idx_valid, illegal, seq_err, corrected, locked;
  logic [7:0]   err_count;

  int checks = 0;
  int fails  = 0;

  // model state
  int m_idx, m_prev, m_run, m_err;
  bit m_locked, m_ivalid, m_ill, m_serr, m_corr;
  int last_fed;

  johnson_decoder #(.WIDTH(W), .LOCK_CNT(LK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
    .err_clr(err_clr), .idx_out(idx_out), .idx_valid(idx_valid),
    .illegal(illegal), .seq_err(seq_err), .corrected(corrected),
    .locked(locked), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Legal code for sequence position i: bottom run of i ones, then top runs.
  function automatic int code_of(int i);
    int full;
    full = (1 << W) - 1;
    if (i <= W) return (1 << i) - 1;
    return full & ~((1 << (i - W)) - 1);
  endfunction

  function automatic int lookup(int c);
    for (int i = 0; i < N; i++) if (code_of(i) == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_prev = -1; m_run = 0; m_err = 0;
    m_locked = 0; m_ivalid = 0; m_ill = 0; m_serr = 0; m_corr = 0;
  endtask

  task automatic model_step(input bit v, input int c, input bit clr);
    int k, ex;
    bit ev;
    ev = 0;
    m_ivalid = 0; m_ill = 0; m_serr = 0; m_corr = 0;
    if (v) begin
      k  = lookup(c);
      ex = (m_prev + 1) % N;
      if (k < 0) begin
`ifdef JOHNSON_DEC_CORRECT_EN
        if (m_locked && $countones(c ^ code_of(ex)) == 1) begin
          m_corr = 1; m_ivalid = 1; m_idx = ex; m_prev = ex;
        end else begin
          m_ill = 1; m_locked = 0; m_run = 0; m_prev = -1; ev = 1;
        end
`else
        m_ill = 1; m_locked = 0; m_run = 0; m_prev = -1; ev = 1;
`endif
      end else begin
        m_ivalid = 1; m_idx = k;
        if (m_locked) begin
          if (k != ex) begin m_serr = 1; ev = 1; m_locked = 0; m_run = 0; end
        end else begin
          if (m_prev >= 0 && k == ex) m_run++; else m_run = 0;
          if (m_run >= LK) m_locked = 1;
        end
        m_prev = k;
      end
    end
    if (clr) m_err = ev ? 1 : 0;
    else if (ev && m_err < 255) m_err++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("idx_out", int'(idx_out), m_idx);
    chk("idx_valid", int'(idx_valid), int'(m_ivalid));
    chk("illegal", int'(illegal), int'(m_ill));
    chk("seq_err", int'(seq_err), int'(m_serr));
    chk("corrected", int'(corrected), int'(m_corr));
    chk("locked", int'(locked), int'(m_locked));
    chk("err_count", int'(err_count), m_err);
  endtask

  task automatic cyc(input bit v, input int c, input bit clr);
    in_valid = v; in_code = W'(c); err_clr = clr;
    @(posedge clk); #1;
    model_step(v, c, clr);
    compare_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_idx"}, int'(idx_out), 0);
    chk({tag, "_vld"}, int'(idx_valid), 0);
    chk({tag, "_ill"}, int'(illegal), 0);
    chk({tag, "_seq"}, int'(seq_err), 0);
    chk({tag, "_cor"}, int'(corrected), 0);
    chk({tag, "_lck"}, int'(locked), 0);
    chk({tag, "_err"}, int'(err_count), 0);
  endtask

  initial begin
    int r, c;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    rst = 1'b1;

    // Initial lock: idx 0..3, lock with idx 3
    cyc(1, 4'b0000, 0); chk("pin_idx0", int'(idx_out), 0); chk("pin_lck0", int'(locked), 0);
    cyc(1, 4'b0001, 0);
    cyc(1, 4'b0011, 0); chk("pin_lck2", int'(locked), 0);
    cyc(1, 4'b0111, 0); chk("pin_idx3", int'(idx_out), 3); chk("pin_lck3", int'(locked), 1);

    // Illegal while locked
    cyc(1, 4'b0101, 0);
    chk("pin_ill", int'(illegal), 1); chk("pin_ill_vld", int'(idx_valid), 0);
    chk("pin_ill_lck", int'(locked), 0); chk("pin_ill_err", int'(err_count), 1);
    chk("pin_ill_hold", int'(idx_out), 3);
    cyc(1, 4'b0001, 0); cyc(1, 4'b0011, 0); cyc(1, 4'b0111, 0);
    chk("pin_relock_pre", int'(locked), 0);
    cyc(1, 4'b1111, 0); chk("pin_relock_idx", int'(idx_out), 4); chk("pin_relock", int'(locked), 1);

    // Walk to idx 2 locked, then skip to 1111
    cyc(1, 4'b1110, 0); cyc(1, 4'b1100, 0); cyc(1, 4'b1000, 0);
    cyc(1, 4'b0000, 0); cyc(1, 4'b0001, 0); cyc(1, 4'b0011, 0);
    chk("pin_lck_at2", int'(locked), 1);
    cyc(1, 4'b1111, 0);
    chk("pin_seq", int'(seq_err), 1); chk("pin_seq_idx", int'(idx_out), 4);
    chk("pin_seq_vld", int'(idx_valid), 1); chk("pin_seq_lck", int'(locked), 0);
    chk("pin_seq_err", int'(err_count), 2);

    // Relock and wrap through 7 -> 0
    cyc(1, 4'b1110, 0); cyc(1, 4'b1100, 0); cyc(1, 4'b1000, 0);
    chk("pin_lck7", int'(locked), 1);
    for (int i = 0; i < 9; i++) cyc(1, code_of(i % N), 0);
    chk("pin_wrap_idx", int'(idx_out), 0); chk("pin_wrap_lck", int'(locked), 1);
    chk("pin_wrap_seq", int'(seq_err), 0); chk("pin_wrap_err", int'(err_count), 2);

    // Single-bit error while locked at 0111 (expected 1111)
    cyc(1, 4'b0001, 0); cyc(1, 4'b0011, 0); cyc(1, 4'b0111, 0);
    cyc(1, 4'b1101, 0);
`ifdef JOHNSON_DEC_CORRECT_EN
    chk("pin_cor", int'(corrected), 1); chk("pin_cor_idx", int'(idx_out), 4);
    chk("pin_cor_lck", int'(locked), 1); chk("pin_cor_err", int'(err_count), 2);
`else
    chk("pin_nocor", int'(corrected), 0); chk("pin_nocor_ill", int'(illegal), 1);
    chk("pin_nocor_err", int'(err_count), 3);
`endif

    // Relock then reset mid-stream
    for (int i = 0; i < N; i++) cyc(1, code_of(i), 0);
    chk("pin_prerst_lck", int'(locked), 1);
    in_valid = 1'b0; rst = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_zero("hold_rst");
    rst = 1'b1;

    // Random traffic
    last_fed = 0;
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(99);
      if (r < 55) begin
        last_fed = (last_fed + 1) % N; c = code_of(last_fed);
      end else if (r < 75) begin
        last_fed = $urandom_range(N - 1); c = code_of(last_fed);
      end else begin
        c = $urandom_range((1 << W) - 1);
      end
      cyc($urandom_range(99) < 85, c, $urandom_range(99) < 3);
    end

    // Saturation and clear behaviour
    for (int i = 0; i < 300; i++) cyc(1, 4'b0101, 0);
    chk("pin_sat", int'(err_count), 255);
    cyc(1, 4'b0101, 1); chk("pin_clr_ev", int'(err_count), 1);
    cyc(0, 4'b0000, 1); chk("pin_clr", int'(err_count), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
